pb_led_ctrl: RTL and testbench

PB_LED_CTRL -- requirements
Module: pb_led_ctrl

---
 rtl/pb_led_ctrl.sv | 154 +++++++++++++++
 tb/tb_pb_led_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pb_led_ctrl.sv
// Pushbutton debouncer with press capture, interrupt, and a blinking
// LED register bank behind a small Avalon-MM slave.
module pb_led_ctrl #(
    parameter int NUM_PB          = 4,
    parameter int NUM_LED         = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BLINK_DIV       = 12500000,
    parameter int PB_ACTIVE_LOW   = 1
) (
    input  logic               clk_clk,
    input  logic               reset_reset,
    input  logic [NUM_PB-1:0]  pb_in,
    input  logic [2:0]         avs_address,
    input  logic               avs_write,
    input  logic               avs_read,
    input  logic [31:0]        avs_writedata,
    output logic [31:0]        avs_readdata,
    output logic [NUM_LED-1:0] led_out,
    output logic [NUM_PB-1:0]  pb_level,
    output logic               irq
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BW-1:0] DIV_MAX = BW'(BLINK_DIV - 1);
    // Raw flops reset to the released level so sync reads "not pressed".
    localparam logic [NUM_PB-1:0] SYNC_RST =
        (PB_ACTIVE_LOW != 0) ? {NUM_PB{1'b1}} : {NUM_PB{1'b0}};

    logic [NUM_PB-1:0]  sync_q1;
    logic [NUM_PB-1:0]  sync_q2;
    logic [NUM_PB-1:0]  sync;
    logic [CW-1:0]      cnt [NUM_PB];
    logic [NUM_PB-1:0]  at_max;
    logic [NUM_PB-1:0]  rise;
    logic [NUM_PB-1:0]  edge_cap;
    logic [NUM_PB-1:0]  cap_clr;
    logic [NUM_PB-1:0]  irq_mask;
    logic [NUM_LED-1:0] led_reg;
    logic [NUM_LED-1:0] blink_mask;
    logic [BW-1:0]      div_cnt;
    logic               blink_phase;
    logic [31:0]        rd_mux;
    logic               wr_led;
    logic               wr_blink;
    logic               wr_irqm;
    logic               wr_cap;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            sync_q1 <= SYNC_RST;
            sync_q2 <= SYNC_RST;
        end else begin
            sync_q1 <= pb_in;
            sync_q2 <= sync_q1;
        end
    end

    assign sync = (PB_ACTIVE_LOW != 0) ? ~sync_q2 : sync_q2;

    always_comb begin
        at_max = '0;
        for (int i = 0; i < NUM_PB; i++) begin
            at_max[i] = (cnt[i] == CNT_MAX);
        end
    end

    assign rise = sync & ~pb_level & at_max;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            for (int i = 0; i < NUM_PB; i++) begin
                cnt[i] <= '0;
            end
            pb_level <= '0;
        end else begin
            for (int i = 0; i < NUM_PB; i++) begin
                if (sync[i] == pb_level[i]) begin
                    cnt[i] <= '0;
                end else if (at_max[i]) begin
                    cnt[i]      <= '0;
                    pb_level[i] <= sync[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign wr_led   = avs_write && (avs_address == 3'd0);
    assign wr_blink = avs_write && (avs_address == 3'd1);
    assign wr_irqm  = avs_write && (avs_address == 3'd2);
    assign wr_cap   = avs_write && (avs_address == 3'd3);
    assign cap_clr  = wr_cap ? avs_writedata[NUM_PB-1:0] : '0;

    // A press landing on the same edge as a W1C clear must survive.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            led_reg    <= '0;
            blink_mask <= '0;
            irq_mask   <= '0;
            edge_cap   <= '0;
        end else begin
            if (wr_led)   led_reg    <= avs_writedata[NUM_LED-1:0];
            if (wr_blink) blink_mask <= avs_writedata[NUM_LED-1:0];
            if (wr_irqm)  irq_mask   <= avs_writedata[NUM_PB-1:0];
            edge_cap <= (edge_cap & ~cap_clr) | rise;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            3'd0:    rd_mux[NUM_LED-1:0] = led_reg;
            3'd1:    rd_mux[NUM_LED-1:0] = blink_mask;
            3'd2:    rd_mux[NUM_PB-1:0]  = irq_mask;
            3'd3:    rd_mux[NUM_PB-1:0]  = edge_cap;
            3'd4:    rd_mux[NUM_PB-1:0]  = pb_level;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            avs_readdata <= rd_mux;
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            div_cnt     <= '0;
            blink_phase <= 1'b0;
        end else if (div_cnt == DIV_MAX) begin
            div_cnt     <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            led_out <= '0;
            irq     <= 1'b0;
        end else begin
            led_out <= led_reg & (~blink_mask | {NUM_LED{blink_phase}});
            irq     <= |(edge_cap & irq_mask);
        end
    end

endmodule

// File: tb/tb_pb_led_ctrl.sv
// Bench for pb_led_ctrl with a short debounce and blink period.
module tb_pb_led_ctrl;

    localparam int NPB = 4;
    localparam int NLED = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [NPB-1:0]  pb_in;
    logic [2:0]      avs_address;
    logic            avs_write;
    logic            avs_read;
    logic [31:0]     avs_writedata;
    logic [31:0]     avs_readdata;
    logic [NLED-1:0] led_out;
    logic [NPB-1:0]  pb_level;
    logic            irq;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] exp;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        bit          wr;
        logic [2:0]  addr;
        logic [31:0] data;
    } vec_t;
    vec_t tbl[26];

    pb_led_ctrl #(
        .NUM_PB(NPB),
        .NUM_LED(NLED),
        .DEBOUNCE_CYCLES(4),
        .BLINK_DIV(3),
        .PB_ACTIVE_LOW(1)
    ) dut (
        .clk_clk(clk),
        .reset_reset(rst),
        .pb_in(pb_in),
        .avs_address(avs_address),
        .avs_write(avs_write),
        .avs_read(avs_read),
        .avs_writedata(avs_writedata),
        .avs_readdata(avs_readdata),
        .led_out(led_out),
        .pb_level(pb_level),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h exp %h", nm, act, exp);
        end
    endtask

    task automatic pop_rd();
        sb_t e;
        if (sbq.size() == 0) begin
            chk("rd_queue_empty", 32'd1, 32'd0);
        end else begin
            e = sbq.pop_front();
            chk($sformatf("rd_addr%0d", e.addr), avs_readdata, e.exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        avs_address = a;
        avs_writedata = d;
        avs_write = 1'b1;
        step();
        avs_write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e);
        avs_address = a;
        avs_read = 1'b1;
        sbq.push_back('{a, e});
        step();
        avs_read = 1'b0;
        pop_rd();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [3:0] prev;
        logic [3:0] exp_lo;
        int k;

        tbl[0]  = '{1'b1, 3'd0, 32'hFFFF_FFFF};
        tbl[1]  = '{1'b1, 3'd1, 32'hFFFF_FFFF};
        tbl[2]  = '{1'b1, 3'd2, 32'hFFFF_FFFF};
        tbl[3]  = '{1'b1, 3'd3, 32'hFFFF_FFFF};
        tbl[4]  = '{1'b1, 3'd4, 32'hFFFF_FFFF};
        tbl[5]  = '{1'b1, 3'd5, 32'hFFFF_FFFF};
        tbl[6]  = '{1'b1, 3'd6, 32'hFFFF_FFFF};
        tbl[7]  = '{1'b1, 3'd7, 32'hFFFF_FFFF};
        tbl[8]  = '{1'b0, 3'd0, 32'h0000_00FF};
        tbl[9]  = '{1'b0, 3'd1, 32'h0000_00FF};
        tbl[10] = '{1'b0, 3'd2, 32'h0000_000F};
        tbl[11] = '{1'b0, 3'd3, 32'h0000_0000};
        tbl[12] = '{1'b0, 3'd4, 32'h0000_0000};
        tbl[13] = '{1'b0, 3'd5, 32'h0000_0000};
        tbl[14] = '{1'b0, 3'd6, 32'h0000_0000};
        tbl[15] = '{1'b0, 3'd7, 32'h0000_0000};
        tbl[16] = '{1'b1, 3'd0, 32'h0000_A5A5};
        tbl[17] = '{1'b0, 3'd0, 32'h0000_00A5};
        tbl[18] = '{1'b1, 3'd2, 32'h0000_1236};
        tbl[19] = '{1'b0, 3'd2, 32'h0000_0006};
        tbl[20] = '{1'b1, 3'd1, 32'h0000_003C};
        tbl[21] = '{1'b0, 3'd1, 32'h0000_003C};
        tbl[22] = '{1'b1, 3'd0, 32'h0000_0000};
        tbl[23] = '{1'b1, 3'd1, 32'h0000_0000};
        tbl[24] = '{1'b1, 3'd2, 32'h0000_0000};
        tbl[25] = '{1'b0, 3'd0, 32'h0000_0000};

        rst = 1'b1;
        pb_in = '1;
        avs_address = '0;
        avs_write = 1'b0;
        avs_read = 1'b0;
        avs_writedata = '0;
        #1;
        chk("rst_led", 32'(led_out), 32'h0);
        chk("rst_level", 32'(pb_level), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_rdata", avs_readdata, 32'h0);
        steps(3);
        rst = 1'b0;
        steps(2);

        for (int i = 0; i < 26; i++) begin
            if (tbl[i].wr) wr(tbl[i].addr, tbl[i].data);
            else rd(tbl[i].addr, tbl[i].data);
        end

        // Press with interrupt enabled.
        wr(3'd2, 32'h1);
        pb_in = 4'b1110;
        steps(5);
        chk("press_lvl_c5", 32'(pb_level), 32'h0);
        step();
        chk("press_lvl_c6", 32'(pb_level), 32'h1);
        chk("press_irq_c6", 32'(irq), 32'h0);
        step();
        chk("press_irq_c7", 32'(irq), 32'h1);
        rd(3'd3, 32'h1);
        rd(3'd4, 32'h1);
        pb_in = 4'b1111;
        steps(6);
        chk("release_lvl", 32'(pb_level), 32'h0);
        rd(3'd3, 32'h1);
        wr(3'd3, 32'h1);
        chk("clr_irq_same", 32'(irq), 32'h1);
        step();
        chk("clr_irq_next", 32'(irq), 32'h0);

        // Glitch shorter than the debounce window.
        pb_in = 4'b1110;
        steps(3);
        pb_in = 4'b1111;
        steps(10);
        chk("glitch_lvl", 32'(pb_level), 32'h0);
        rd(3'd3, 32'h0);
        pb_in = 4'b1110;
        steps(6);
        chk("hold4_lvl", 32'(pb_level), 32'h1);
        pb_in = 4'b1111;
        steps(6);
        wr(3'd3, 32'hF);
        rd(3'd3, 32'h0);

        // Clear coinciding with a fresh press.
        pb_in = 4'b1110;
        steps(5);
        chk("race_lvl_c5", 32'(pb_level), 32'h0);
        wr(3'd3, 32'h1);
        chk("race_lvl_c6", 32'(pb_level), 32'h1);
        rd(3'd3, 32'h1);
        chk("race_irq", 32'(irq), 32'h1);
        wr(3'd3, 32'h1);
        chk("race_irq_hold", 32'(irq), 32'h1);
        rd(3'd3, 32'h0);
        chk("race_irq_drop", 32'(irq), 32'h0);
        pb_in = 4'b1111;
        steps(6);

        // Blink on the low nibble only.
        wr(3'd0, 32'hFF);
        wr(3'd1, 32'h0F);
        steps(2);
        prev = led_out[3:0];
        k = 0;
        while (k < 4 && led_out[3:0] == prev) begin
            step();
            k++;
        end
        chk("blink_toggle_seen", 32'(k < 4), 32'h1);
        exp_lo = ~prev;
        for (int p = 0; p < 4; p++) begin
            for (int j = 0; j < 3; j++) begin
                chk("blink_lo", 32'(led_out[3:0]), 32'(exp_lo));
                chk("blink_hi", 32'(led_out[7:4]), 32'hF);
                step();
            end
            exp_lo = ~exp_lo;
        end
        wr(3'd1, 32'h0);
        wr(3'd0, 32'h3C);
        steps(2);
        chk("led_static", 32'(led_out), 32'h3C);

        // Read and write to the same register in one cycle.
        avs_address = 3'd0;
        avs_writedata = 32'h11;
        avs_write = 1'b1;
        avs_read = 1'b1;
        sbq.push_back('{3'd0, 32'h3C});
        step();
        avs_write = 1'b0;
        avs_read = 1'b0;
        pop_rd();
        rd(3'd0, 32'h11);
        step();
        chk("rd_hold", avs_readdata, 32'h11);

        // Reset while channel 1 is part way through debouncing.
        pb_in = 4'b1101;
        steps(5);
        rst = 1'b1;
        #1;
        chk("mid_rst_lvl", 32'(pb_level), 32'h0);
        chk("mid_rst_led", 32'(led_out), 32'h0);
        chk("mid_rst_rdata", avs_readdata, 32'h0);
        step();
        rst = 1'b0;
        steps(5);
        chk("post_rst_c5", 32'(pb_level), 32'h0);
        step();
        chk("post_rst_c6", 32'(pb_level), 32'h2);
        rd(3'd3, 32'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
